led_pwm_driver: RTL and testbench
=================================

Name: led_pwm_driver

Overview:
- Downstream of the APB LED register block: consumes its 32-bit LED value word and drives the physical LED pins.
- Adds global PWM brightness dimming, per-LED blink masking and glitch-free update.
- LED value and duty are shadowed and take effect only at a PWM period boundary.
- Runs on the APB clock domain.

Parameters:
NUM_LED, 32, number of LED outputs (width of value/mask/output buses)
CLK_DIV, 4, PCLK cycles per PWM step (>=1)
BLINK_W, 16, width of blink half-period count

Ports:
PCLK  input  1  clock
PRESETn  input  1  reset, asynchronous, active-low
i_enable  input  1  driver enable; 0 forces outputs off and restarts timing
i_led_value  input  NUM_LED  LED on/off word from LED register block
i_duty  input  8  global brightness, 0 = off, 255 = fully on
i_blink_en  input  1  blink enable
i_blink_mask  input  NUM_LED  1 = LED participates in blinking
i_blink_half  input  BLINK_W  PWM periods per blink half-cycle (0 treated as 1)
o_led  output  NUM_LED  registered LED drive
o_frame  output  1  one-cycle pulse at start of each PWM period
o_blink_phase  output  1  current blink phase (1 = on half)

Behaviour:
- Reset: o_led=0, o_frame=0, o_blink_phase=1; all counters and shadow registers 0.
- Divider div_cnt counts 0..CLK_DIV-1; tick asserted in the cycle div_cnt==CLK_DIV-1, then div_cnt wraps to 0.
- PWM counter pwm_cnt: 0..254, advances on tick, wraps 254->0; period = 255*CLK_DIV PCLK cycles.
- pwm_on = (pwm_cnt < sh_duty); duty 0 never on, duty 255 always on.
- Shadows sh_value/sh_duty load i_led_value/i_duty on the tick where pwm_cnt==254 (wrap). Mid-period input changes have no effect until the next period.
- o_frame: registered pulse, high for exactly one cycle, the cycle after the wrap tick (pwm_cnt==0 first cycle).
- Blink counter blink_cnt advances once per period wrap while i_blink_en=1. When blink_cnt >= max(i_blink_half,1)-1: blink_cnt=0 and phase toggles. The >= compare lets a shrinking i_blink_half never overrun.
- i_blink_en=0: blink_cnt=0, phase forced 1.
- o_led[i] (registered, 1-cycle latency from internal state) = i_enable & sh_value[i] & pwm_on & (~i_blink_mask[i] | phase).
- i_enable=0: div_cnt, pwm_cnt, blink_cnt cleared; phase=1; shadows load every cycle; o_led=0 next cycle; o_frame=0.
- First cycle with i_enable=1 starts a period at pwm_cnt=0 using the last-loaded shadows. No o_frame for this restart period; the first o_frame follows the first wrap.
- Simultaneous wrap and blink toggle: both take effect at the same edge; the new period uses the new phase.
- Async reset mid-period: all state and outputs return to reset values immediately; no partial-period glitch after release.

Test Plan:
- Reset: hold PRESETn=0 with random inputs -> o_led=0, o_frame=0, o_blink_phase=1; release, i_enable=0 -> o_led stays 0.
- Duty: CLK_DIV=1, value=0xFFFFFFFF, duty=64, enable -> each period 255 cycles; o_led=all-ones for 64 cycles then 0 for 191; duty=0 -> always 0; duty=255 -> always all-ones.
- Shadow: change i_led_value 0x0000000F->0x000000F0 mid-period -> o_led keeps 0x0F pattern until the cycle after o_frame, then shows 0xF0.
- Blink: duty=255, mask=0x0000FFFF, value=all-ones, half=2, blink_en=1 -> upper 16 bits always on; lower 16 toggle every 2 periods (510 cycles at CLK_DIV=1); half=0 toggles every period.
- Disable: drop i_enable mid-period -> o_led=0 next cycle, counters cleared. Re-enable -> PWM restarts at pwm_cnt=0 with the latest value/duty; first o_frame exactly 255*CLK_DIV cycles later.
- Async reset: assert PRESETn=0 mid-blink off-phase -> o_led=0 and o_blink_phase=1 without waiting for a PCLK edge.

Source files
------------

// File: rtl/led_pwm_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : led_pwm_driver_if
// Brief    : Control/status bundle between the LED register block and the
//            LED PWM driver.
// Revision : 1.0
// ============================================================================
interface led_pwm_driver_if #(
  parameter int NUM_LED = 32,
  parameter int BLINK_W = 16
);
  logic               i_enable;
  logic [NUM_LED-1:0] i_led_value;
  logic [7:0]         i_duty;
  logic               i_blink_en;
  logic [NUM_LED-1:0] i_blink_mask;
  logic [BLINK_W-1:0] i_blink_half;
  logic [NUM_LED-1:0] o_led;
  logic               o_frame;
  logic               o_blink_phase;

  modport master (
    output i_enable, i_led_value, i_duty, i_blink_en, i_blink_mask, i_blink_half,
    input  o_led, o_frame, o_blink_phase
  );

  modport slave (
    input  i_enable, i_led_value, i_duty, i_blink_en, i_blink_mask, i_blink_half,
    output o_led, o_frame, o_blink_phase
  );
endinterface
`default_nettype wire

// File: rtl/led_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : led_pwm_driver
// Brief    : Global PWM dimming, per-LED blink and period-aligned shadowing
//            of the LED value word.
// Revision : 1.0
// ============================================================================
module led_pwm_driver #(
  parameter int NUM_LED = 32,
  parameter int CLK_DIV = 4,
  parameter int BLINK_W = 16
) (
  input  wire logic        PCLK,
  input  wire logic        PRESETn,
  led_pwm_driver_if.slave  bus
);
  localparam int          c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [7:0]  c_PWM_LAST = 8'd254;

  logic [c_DIV_W-1:0] r_div_cnt;
  logic [7:0]         r_pwm_cnt;
  logic [NUM_LED-1:0] r_sh_value;
  logic [7:0]         r_sh_duty;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_phase;
  logic [NUM_LED-1:0] r_led;
  logic               r_frame;

  logic               w_tick;
  logic               w_wrap;
  logic               w_pwm_on;
  logic [BLINK_W-1:0] w_half_m1;
  logic [NUM_LED-1:0] w_led_next;

  assign w_tick   = (r_div_cnt == c_DIV_W'(CLK_DIV - 1));
  assign w_wrap   = w_tick && (r_pwm_cnt == c_PWM_LAST);
  assign w_pwm_on = (r_pwm_cnt < r_sh_duty);
  // A half-period of 0 behaves like 1 so blink never stalls.
  assign w_half_m1 = (bus.i_blink_half == '0) ? '0 : bus.i_blink_half - BLINK_W'(1);

  assign w_led_next = (bus.i_enable && w_pwm_on)
                    ? (r_sh_value & (~bus.i_blink_mask | {NUM_LED{r_phase}}))
                    : '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_div_cnt   <= '0;
      r_pwm_cnt   <= '0;
      r_sh_value  <= '0;
      r_sh_duty   <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
      r_led       <= '0;
      r_frame     <= 1'b0;
    end else begin
      r_led <= w_led_next;
      if (!bus.i_enable) begin
        // Shadows track the inputs so re-enable starts with fresh values.
        r_div_cnt   <= '0;
        r_pwm_cnt   <= '0;
        r_sh_value  <= bus.i_led_value;
        r_sh_duty   <= bus.i_duty;
        r_blink_cnt <= '0;
        r_phase     <= 1'b1;
        r_frame     <= 1'b0;
      end else begin
        r_frame   <= w_wrap;
        r_div_cnt <= w_tick ? '0 : r_div_cnt + c_DIV_W'(1);
        if (w_tick) begin
          r_pwm_cnt <= w_wrap ? 8'd0 : r_pwm_cnt + 8'd1;
        end
        if (w_wrap) begin
          r_sh_value <= bus.i_led_value;
          r_sh_duty  <= bus.i_duty;
        end
        if (!bus.i_blink_en) begin
          r_blink_cnt <= '0;
          r_phase     <= 1'b1;
        end else if (w_wrap) begin
          // >= rather than == so a shrinking half-period cannot overrun.
          if (r_blink_cnt >= w_half_m1) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
          end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
          end
        end
      end
    end
  end

  assign bus.o_led         = r_led;
  assign bus.o_frame       = r_frame;
  assign bus.o_blink_phase = r_phase;
endmodule
`default_nettype wire

// File: tb/tb_led_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pwm_driver
// Brief    : Directed self-checking bench; one DUT at CLK_DIV=1, one at 4.
// Revision : 1.0
// ============================================================================
module tb_led_pwm_driver;
  logic PCLK = 1'b0;
  logic PRESETn;
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] c_ONES = 32'hFFFF_FFFF;

  always #5 PCLK = ~PCLK;

  led_pwm_driver_if #(.NUM_LED(32), .BLINK_W(16)) bus1 ();
  led_pwm_driver_if #(.NUM_LED(32), .BLINK_W(16)) bus4 ();

  assign bus4.i_enable     = bus1.i_enable;
  assign bus4.i_led_value  = bus1.i_led_value;
  assign bus4.i_duty       = bus1.i_duty;
  assign bus4.i_blink_en   = bus1.i_blink_en;
  assign bus4.i_blink_mask = bus1.i_blink_mask;
  assign bus4.i_blink_half = bus1.i_blink_half;

  led_pwm_driver #(.NUM_LED(32), .CLK_DIV(1), .BLINK_W(16)) dut1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus1.slave));
  led_pwm_driver #(.NUM_LED(32), .CLK_DIV(4), .BLINK_W(16)) dut4 (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus4.slave));

  task automatic cyc();
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  task automatic restart(input logic [31:0] v, input logic [7:0] d);
    bus1.i_enable    = 1'b0;
    bus1.i_led_value = v;
    bus1.i_duty      = d;
    cyc();
    cyc();
    bus1.i_enable = 1'b1;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    bus1.i_enable     = 1'b1;
    bus1.i_led_value  = $urandom;
    bus1.i_duty       = 8'($urandom);
    bus1.i_blink_en   = 1'b1;
    bus1.i_blink_mask = $urandom;
    bus1.i_blink_half = 16'($urandom);
    repeat (3) cyc();
    checks++; if (bus1.o_led !== '0) begin errors++; $display("FAIL reset_led: got %h expected 0", bus1.o_led); end
    checks++; if (bus1.o_frame !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b expected 0", bus1.o_frame); end
    checks++; if (bus1.o_blink_phase !== 1'b1) begin errors++; $display("FAIL reset_phase: got %b expected 1", bus1.o_blink_phase); end
    checks++; if (bus4.o_led !== '0) begin errors++; $display("FAIL reset_led4: got %h expected 0", bus4.o_led); end
    bus1.i_enable = 1'b0;
    PRESETn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++; if (bus1.o_led !== '0) begin errors++; $display("FAIL reset_disabled_led k=%0d: got %h expected 0", k, bus1.o_led); end
    end
  endtask

  task automatic test_duty();
    logic [31:0] e1, e4;
    bus1.i_blink_en   = 1'b0;
    bus1.i_blink_mask = '0;
    bus1.i_blink_half = '0;
    restart(c_ONES, 8'd64);
    for (int k = 0; k < 510; k++) begin
      cyc();
      e1 = ((k % 255) < 64) ? c_ONES : '0;
      e4 = ((k / 4) < 64) ? c_ONES : '0;
      checks++; if (bus1.o_led !== e1) begin errors++; $display("FAIL duty64_led k=%0d: got %h expected %h", k, bus1.o_led, e1); end
      checks++; if (bus1.o_frame !== ((k % 255) == 254)) begin errors++; $display("FAIL duty64_frame k=%0d: got %b expected %b", k, bus1.o_frame, (k % 255) == 254); end
      checks++; if (bus4.o_led !== e4) begin errors++; $display("FAIL duty64_led_div4 k=%0d: got %h expected %h", k, bus4.o_led, e4); end
    end
    restart(c_ONES, 8'd0);
    for (int k = 0; k < 300; k++) begin
      cyc();
      checks++; if (bus1.o_led !== '0) begin errors++; $display("FAIL duty0_led k=%0d: got %h expected 0", k, bus1.o_led); end
    end
    restart(c_ONES, 8'd255);
    for (int k = 0; k < 300; k++) begin
      cyc();
      checks++; if (bus1.o_led !== c_ONES) begin errors++; $display("FAIL duty255_led k=%0d: got %h expected %h", k, bus1.o_led, c_ONES); end
    end
  endtask

  task automatic test_shadow();
    logic [31:0] e;
    restart(32'h0000_000F, 8'd255);
    for (int k = 0; k < 300; k++) begin
      cyc();
      e = (k <= 254) ? 32'h0000_000F : 32'h0000_00F0;
      checks++; if (bus1.o_led !== e) begin errors++; $display("FAIL shadow_led k=%0d: got %h expected %h", k, bus1.o_led, e); end
      if (k == 100) bus1.i_led_value = 32'h0000_00F0;
    end
  endtask

  task automatic test_blink();
    logic [31:0] e;
    logic        ep;
    bus1.i_blink_en   = 1'b1;
    bus1.i_blink_mask = 32'h0000_FFFF;
    bus1.i_blink_half = 16'd2;
    restart(c_ONES, 8'd255);
    for (int k = 0; k < 1100; k++) begin
      cyc();
      e  = (((k / 510) % 2) == 0) ? c_ONES : 32'hFFFF_0000;
      ep = (((k + 1) / 510) % 2) == 0;
      checks++; if (bus1.o_led !== e) begin errors++; $display("FAIL blink2_led k=%0d: got %h expected %h", k, bus1.o_led, e); end
      checks++; if (bus1.o_blink_phase !== ep) begin errors++; $display("FAIL blink2_phase k=%0d: got %b expected %b", k, bus1.o_blink_phase, ep); end
    end
    bus1.i_blink_half = 16'd0;
    restart(c_ONES, 8'd255);
    for (int k = 0; k < 600; k++) begin
      cyc();
      e  = (((k / 255) % 2) == 0) ? c_ONES : 32'hFFFF_0000;
      ep = (((k + 1) / 255) % 2) == 0;
      checks++; if (bus1.o_led !== e) begin errors++; $display("FAIL blink0_led k=%0d: got %h expected %h", k, bus1.o_led, e); end
      checks++; if (bus1.o_blink_phase !== ep) begin errors++; $display("FAIL blink0_phase k=%0d: got %b expected %b", k, bus1.o_blink_phase, ep); end
    end
    bus1.i_blink_en = 1'b0;
  endtask

  task automatic test_disable();
    logic [31:0] e1, e4;
    restart(32'h1234_5678, 8'd255);
    repeat (100) cyc();
    bus1.i_enable = 1'b0;
    cyc();
    checks++; if (bus1.o_led !== '0) begin errors++; $display("FAIL disable_led: got %h expected 0", bus1.o_led); end
    checks++; if (bus4.o_led !== '0) begin errors++; $display("FAIL disable_led4: got %h expected 0", bus4.o_led); end
    checks++; if (bus1.o_frame !== 1'b0) begin errors++; $display("FAIL disable_frame: got %b expected 0", bus1.o_frame); end
    bus1.i_led_value = 32'hA5A5_A5A5;
    bus1.i_duty      = 8'd128;
    cyc();
    bus1.i_enable = 1'b1;
    for (int k = 0; k < 1031; k++) begin
      cyc();
      e1 = ((k % 255) < 128) ? 32'hA5A5_A5A5 : '0;
      e4 = (((k % 1020) / 4) < 128) ? 32'hA5A5_A5A5 : '0;
      checks++; if (bus1.o_led !== e1) begin errors++; $display("FAIL reenable_led k=%0d: got %h expected %h", k, bus1.o_led, e1); end
      checks++; if (bus1.o_frame !== ((k % 255) == 254)) begin errors++; $display("FAIL reenable_frame k=%0d: got %b expected %b", k, bus1.o_frame, (k % 255) == 254); end
      checks++; if (bus4.o_led !== e4) begin errors++; $display("FAIL reenable_led4 k=%0d: got %h expected %h", k, bus4.o_led, e4); end
      checks++; if (bus4.o_frame !== (k == 1019)) begin errors++; $display("FAIL reenable_frame4 k=%0d: got %b expected %b", k, bus4.o_frame, k == 1019); end
    end
  endtask

  task automatic test_async_reset();
    bus1.i_blink_en   = 1'b1;
    bus1.i_blink_mask = 32'h0000_FFFF;
    bus1.i_blink_half = 16'd1;
    restart(c_ONES, 8'd255);
    repeat (300) cyc();
    checks++; if (bus1.o_blink_phase !== 1'b0) begin errors++; $display("FAIL pre_reset_phase: got %b expected 0", bus1.o_blink_phase); end
    checks++; if (bus1.o_led !== 32'hFFFF_0000) begin errors++; $display("FAIL pre_reset_led: got %h expected ffff0000", bus1.o_led); end
    #1 PRESETn = 1'b0;
    #1;
    checks++; if (bus1.o_led !== '0) begin errors++; $display("FAIL async_led: got %h expected 0", bus1.o_led); end
    checks++; if (bus1.o_blink_phase !== 1'b1) begin errors++; $display("FAIL async_phase: got %b expected 1", bus1.o_blink_phase); end
    checks++; if (bus1.o_frame !== 1'b0) begin errors++; $display("FAIL async_frame: got %b expected 0", bus1.o_frame); end
    repeat (3) cyc();
    PRESETn = 1'b1;
    for (int k = 0; k < 255; k++) begin
      cyc();
      checks++; if (bus1.o_led !== '0) begin errors++; $display("FAIL post_reset_led k=%0d: got %h expected 0", k, bus1.o_led); end
      checks++; if (bus1.o_frame !== (k == 254)) begin errors++; $display("FAIL post_reset_frame k=%0d: got %b expected %b", k, bus1.o_frame, k == 254); end
    end
  endtask

  initial begin
    test_reset();
    test_duty();
    test_shadow();
    test_blink();
    test_disable();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
